// File: rtl/piece_collision_engine.sv
// Multi-cycle collision/landing checker: scans one piece row per clock against the fixed board.
// Optional hard-drop distance search enabled by defining PIECE_GHOST_DROP_EN.
module piece_collision_engine #(
  parameter int BOARD_WIDTH  = 10,
  parameter int BOARD_HEIGHT = 20,
  parameter int GRID_SIZE    = 4,
  parameter int POS_W        = 6
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic [BOARD_WIDTH*BOARD_HEIGHT-1:0]         fixed_screen,
  input  logic                                        req_valid,
  output logic                                        req_ready,
  input  logic [GRID_SIZE*GRID_SIZE-1:0]              req_piece,
  input  logic [POS_W-1:0]                            req_x,
  input  logic [POS_W-1:0]                            req_y,
  output logic                                        resp_valid,
  input  logic                                        resp_ready,
  output logic                                        resp_collide,
  output logic                                        resp_wall,
  output logic                                        resp_floor,
  output logic                                        resp_overlap,
  output logic                                        resp_touching,
  output logic [$clog2(BOARD_HEIGHT+GRID_SIZE+1)-1:0] resp_drop_dist
);

  localparam int W  = BOARD_WIDTH;
  localparam int H  = BOARD_HEIGHT;
  localparam int G  = GRID_SIZE;
  localparam int DW = $clog2(H+G+1);
  localparam int IW = $clog2(W*H);
  localparam int RW = $clog2(G+1);
  // Coordinate width leaves headroom for row offset plus the largest drop offset.
  localparam int CW = POS_W + DW + 2;
  localparam logic signed [CW-1:0] W_S   = CW'(W);
  localparam logic signed [CW-1:0] H_S   = CW'(H);
  localparam logic signed [CW-1:0] ONE_S = CW'(1);

`ifdef PIECE_GHOST_DROP_EN
  typedef enum logic [1:0] {IDLE, SCAN, DROP, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
`endif

  state_t                  state_q;
  logic [RW-1:0]           row_q;
  logic [G*G-1:0]          piece_q;
  logic signed [CW-1:0]    x_q, y_q;
  logic                    req_ready_q, resp_valid_q;
  logic                    wall_q, floor_q, overlap_q, touch_q, nonempty_q;

  function automatic logic fixed_at(input logic signed [CW-1:0] wx,
                                    input logic signed [CW-1:0] wy);
    logic [IW-1:0] idx;
    idx = IW'(wx) * IW'(H) + IW'(H - 1) - IW'(wy);
    return fixed_screen[idx];
  endfunction

  logic [G-1:0] row_bits;
  logic         scan_wall, scan_floor, scan_overlap, scan_touch;

  always_comb begin
    row_bits     = '0;
    scan_wall    = 1'b0;
    scan_floor   = 1'b0;
    scan_overlap = 1'b0;
    scan_touch   = 1'b0;
    for (int r = 0; r < G; r++) begin
      if (row_q == RW'(r)) row_bits = piece_q[r*G +: G];
    end
    for (int c = 0; c < G; c++) begin
      logic signed [CW-1:0] wx, wy, wy1;
      logic                 in_x;
      wx   = x_q + CW'(c);
      wy   = y_q + $signed({{(CW-RW){1'b0}}, row_q});
      wy1  = wy + ONE_S;
      in_x = !wx[CW-1] && (wx < W_S);
      if (row_bits[c]) begin
        if (!in_x) scan_wall = 1'b1;
        if (wy >= H_S) scan_floor = 1'b1;
        if (in_x && !wy[CW-1] && (wy < H_S) && fixed_at(wx, wy)) scan_overlap = 1'b1;
        // A cell just above the board (wy = -1) still rests on row 0.
        if (in_x && (wy1 == H_S || (!wy1[CW-1] && wy1 < H_S && fixed_at(wx, wy1))))
          scan_touch = 1'b1;
      end
    end
  end

`ifdef PIECE_GHOST_DROP_EN
  logic [DW-1:0] d_q, drop_q;
  logic          drop_hit;

  always_comb begin
    drop_hit = 1'b0;
    for (int r = 0; r < G; r++) begin
      for (int c = 0; c < G; c++) begin
        logic signed [CW-1:0] wx, wy;
        wx = x_q + CW'(c);
        wy = y_q + CW'(r) + $signed({{(CW-DW){1'b0}}, d_q});
        if (piece_q[r*G+c]) begin
          if (wy >= H_S) drop_hit = 1'b1;
          else if (!wy[CW-1] && !wx[CW-1] && wx < W_S && fixed_at(wx, wy)) drop_hit = 1'b1;
        end
      end
    end
  end

  assign resp_drop_dist = drop_q;
`else
  assign resp_drop_dist = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      row_q        <= '0;
      piece_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      wall_q       <= 1'b0;
      floor_q      <= 1'b0;
      overlap_q    <= 1'b0;
      touch_q      <= 1'b0;
      nonempty_q   <= 1'b0;
`ifdef PIECE_GHOST_DROP_EN
      d_q          <= '0;
      drop_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            piece_q     <= req_piece;
            x_q         <= {{(CW-POS_W){req_x[POS_W-1]}}, req_x};
            y_q         <= {{(CW-POS_W){req_y[POS_W-1]}}, req_y};
            row_q       <= '0;
            wall_q      <= 1'b0;
            floor_q     <= 1'b0;
            overlap_q   <= 1'b0;
            touch_q     <= 1'b0;
            nonempty_q  <= |req_piece;
            req_ready_q <= 1'b0;
`ifdef PIECE_GHOST_DROP_EN
            drop_q      <= '0;
`endif
            state_q     <= SCAN;
          end
        end
        SCAN: begin
          // row_q == G is the settle cycle: all rows accumulated, decide DONE or DROP.
          if (row_q == RW'(G)) begin
`ifdef PIECE_GHOST_DROP_EN
            if (nonempty_q && !(wall_q || floor_q || overlap_q)) begin
              d_q     <= DW'(1);
              state_q <= DROP;
            end else begin
              resp_valid_q <= 1'b1;
              state_q      <= DONE;
            end
`else
            resp_valid_q <= 1'b1;
            state_q      <= DONE;
`endif
          end else begin
            wall_q    <= wall_q    | scan_wall;
            floor_q   <= floor_q   | scan_floor;
            overlap_q <= overlap_q | scan_overlap;
            touch_q   <= touch_q   | scan_touch;
            row_q     <= row_q + RW'(1);
          end
        end
`ifdef PIECE_GHOST_DROP_EN
        DROP: begin
          if (drop_hit) begin
            drop_q       <= d_q - DW'(1);
            resp_valid_q <= 1'b1;
            state_q      <= DONE;
          end else if (d_q == DW'(H+G)) begin
            drop_q       <= d_q;
            resp_valid_q <= 1'b1;
            state_q      <= DONE;
          end else begin
            d_q <= d_q + DW'(1);
          end
        end
`endif
        DONE: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_wall     = wall_q;
  assign resp_floor    = floor_q;
  assign resp_overlap  = overlap_q;
  assign resp_touching = touch_q;
  assign resp_collide  = wall_q | floor_q | overlap_q;

endmodule
